// File: rtl/lu_pkg.sv
// Shared types for the slice-serial logic unit: op encoding and FSM states.
package lu_pkg;

  typedef enum logic [2:0] {
    LU_AND   = 3'b000,
    LU_OR    = 3'b001,
    LU_XOR   = 3'b010,
    LU_NAND  = 3'b011,
    LU_NOR   = 3'b100,
    LU_XNOR  = 3'b101,
    LU_ANDN  = 3'b110,
    LU_PASSA = 3'b111
  } lu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } lu_state_t;

endpackage

// File: rtl/lu_slice.sv
// Combinational W-bit logic slice: every function is built from per-bit gate
// primitives and the op selects one of them.
module lu_slice
  import lu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  lu_op_t       op,
  output logic [W-1:0] y
);

  logic [W-1:0] and_s, or_s, xor_s, nand_s, nor_s, xnor_s, nb_s, andn_s;

  for (genvar i = 0; i < W; i++) begin : g_bit
    and  u_and  (and_s[i],  a[i], b[i]);
    or   u_or   (or_s[i],   a[i], b[i]);
    xor  u_xor  (xor_s[i],  a[i], b[i]);
    nand u_nand (nand_s[i], a[i], b[i]);
    nor  u_nor  (nor_s[i],  a[i], b[i]);
    xnor u_xnor (xnor_s[i], a[i], b[i]);
    not  u_nb   (nb_s[i],   b[i]);
    and  u_andn (andn_s[i], a[i], nb_s[i]);
  end

  // Function select
  always_comb begin
    y = {W{1'b0}};
    case (op)
      LU_AND:   y = and_s;
      LU_OR:    y = or_s;
      LU_XOR:   y = xor_s;
      LU_NAND:  y = nand_s;
      LU_NOR:   y = nor_s;
      LU_XNOR:  y = xnor_s;
      LU_ANDN:  y = andn_s;
      LU_PASSA: y = a;
      default:  y = {W{1'b0}};
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Slice-serial bitwise logic unit with valid/ready handshakes on both sides.
// Build option LU_FLAGS_EN enables the zero/all-ones result flags.
module logic_unit_seq
  import lu_pkg::*;
#(
  parameter int N     = 32,
  parameter int SLICE = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] in_1,
  input  logic [N-1:0] in_2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         zero,
  output logic         ones
);

  localparam int NS = N / SLICE;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NS - 1);

  lu_state_t      state_r, state_s;
  logic [N-1:0]   a_r, b_r, out_r;
  lu_op_t         op_r;
  logic [CW-1:0]  cnt_r;
  logic           in_ready_r, out_valid_r;
  logic [SLICE-1:0] a_sl_s, b_sl_s, res_sl_s;

  assign a_sl_s = a_r[int'(cnt_r)*SLICE +: SLICE];
  assign b_sl_s = b_r[int'(cnt_r)*SLICE +: SLICE];

  lu_slice #(.W(SLICE)) u_slice (
    .a  (a_sl_s),
    .b  (b_sl_s),
    .op (op_r),
    .y  (res_sl_s)
  );

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CNT_LAST) state_s = DONE;
        else                   state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register with handshake flags decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture, slice counter and result write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= {N{1'b0}};
      b_r   <= {N{1'b0}};
      op_r  <= LU_AND;
      cnt_r <= {CW{1'b0}};
      out_r <= {N{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r   <= in_1;
            b_r   <= in_2;
            op_r  <= lu_op_t'(op);
            cnt_r <= {CW{1'b0}};
          end
        end
        RUN: begin
          out_r[int'(cnt_r)*SLICE +: SLICE] <= res_sl_s;
          // Counter parks on the last slice so NS=1 never indexes past out.
          if (cnt_r != CNT_LAST) cnt_r <= cnt_r + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef LU_FLAGS_EN
  logic zero_r, ones_r;

  // Zero/all-ones accumulators, folded one slice per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_r <= 1'b0;
      ones_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            zero_r <= 1'b1;
            ones_r <= 1'b1;
          end
        end
        RUN: begin
          zero_r <= zero_r & (res_sl_s == {SLICE{1'b0}});
          ones_r <= ones_r & (res_sl_s == {SLICE{1'b1}});
        end
        default: ;
      endcase
    end
  end

  assign zero = zero_r;
  assign ones = ones_r;
`else
  assign zero = 1'b0;
  assign ones = 1'b0;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out       = out_r;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed self-checking bench for logic_unit_seq (N=32, SLICE=8) plus
// SLICE=32 and SLICE=1 instances for the latency sweep.
module tb_logic_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] in_1, in_2;
  logic        in_ready, out_valid, zero, ones;
  logic [31:0] out;

  logic        sw_valid, sw_ready;
  logic [2:0]  sw_op;
  logic [31:0] sw_in1, sw_in2;
  logic        s1_in_ready, s1_out_valid, s1_zero, s1_ones;
  logic        s32_in_ready, s32_out_valid, s32_zero, s32_ones;
  logic [31:0] s1_out, s32_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_unit_seq #(.N(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in_1(in_1), .in_2(in_2), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .ones(ones));

  logic_unit_seq #(.N(32), .SLICE(32)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s1_in_ready), .op(sw_op),
    .in_1(sw_in1), .in_2(sw_in2), .out_valid(s1_out_valid), .out_ready(sw_ready),
    .out(s1_out), .zero(s1_zero), .ones(s1_ones));

  logic_unit_seq #(.N(32), .SLICE(1)) dut_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s32_in_ready), .op(sw_op),
    .in_1(sw_in1), .in_2(sw_in2), .out_valid(s32_out_valid), .out_ready(sw_ready),
    .out(s32_out), .zero(s32_zero), .ones(s32_ones));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] o);
    case (o)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return a;
    endcase
  endfunction

  function automatic logic exp_zero(input logic [31:0] r);
`ifdef LU_FLAGS_EN
    return (r == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_ones(input logic [31:0] r);
`ifdef LU_FLAGS_EN
    return (r == 32'hFFFF_FFFF);
`else
    return 1'b0;
`endif
  endfunction

  // Present an operation and return #1 after its accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
    int t = 0;
    @(negedge clk);
    in_1 = a; in_2 = b; op = o; in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("hs_in_ready", 32'(in_ready), 32'd1);
    check("hs_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Full single transaction with latency, result and flag checks
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] o);
    int lat;
    logic [31:0] r;
    r = ref_op(a, b, o);
    start_op(a, b, o);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_out"}, out, r);
    check({tag, "_zero"}, 32'(zero), 32'(exp_zero(r)));
    check({tag, "_ones"}, 32'(ones), 32'(exp_ones(r)));
    finish_op();
  endtask

  initial begin
    int lat, lat1, lat32;
    logic [31:0] held;
    logic [31:0] ta [0:8];
    logic [31:0] tb [0:8];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; in_1 = 32'h0; in_2 = 32'h0;
    sw_valid = 1'b0; sw_ready = 1'b0; sw_op = 3'd0; sw_in1 = 32'h0; sw_in2 = 32'h0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", out, 32'h0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_ones", 32'(ones), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic functions and flag corners
    run_op("and", 32'hF0F0_1234, 32'hFF00_FFFF, 3'd0);
    check("and_value", out, 32'hF000_1234);
    run_op("xor_eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd2);
    run_op("nor_00", 32'h0, 32'h0, 3'd4);
    check("nor_value", out, 32'hFFFF_FFFF);

    // Backpressure: result held, new requests ignored
    start_op(32'h0F0F_0F0F, 32'h00FF_00FF, 3'd0);
    wait_done(lat);
    held = 32'h000F_000F;
    check("bp_out", out, held);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid; in_1 = $urandom; in_2 = $urandom; op = 3'd7;
      @(negedge clk);
      check("bp_hold_out", out, held);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    finish_op();
    repeat (2) @(posedge clk);
    #1;
    check("bp_not_taken", out, held);
    check("bp_idle", 32'(in_ready), 32'd1);

    // Asynchronous reset after two ANDN slices
    start_op(32'hFFFF_FFFF, 32'h0F0F_0F0F, 3'd6);
    repeat (2) @(posedge clk);
    #2;
    check("partial_out", out, 32'h000F_F0F0);
    rst_n = 1'b0;
    #1;
    check("arst_out", out, 32'h0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("passa", 32'h1234_5678, 32'hA5A5_A5A5, 3'd7);
    check("passa_value", out, 32'h1234_5678);

    // Back-to-back over all eight functions
    for (int i = 0; i < 9; i++) begin
      ta[i] = $urandom;
      tb[i] = $urandom;
    end
    @(negedge clk);
    in_1 = ta[0]; in_2 = tb[0]; op = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      in_1 = ta[i+1]; in_2 = tb[i+1]; op = 3'((i + 1) % 8);
      wait_done(lat);
      check("b2b_lat", 32'(lat), 32'd4);
      check("b2b_out", out, ref_op(ta[i], tb[i], 3'(i)));
      @(posedge clk);
      #1;
      check("b2b_idle", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check("b2b_accept", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    wait_done(lat);
    check("b2b_tail", out, ref_op(ta[8], tb[8], 3'd0));
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Slice-width sweep: NS=1 and NS=32 side by side
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sw_in1 = $urandom; sw_in2 = $urandom; sw_op = (k == 0) ? 3'd2 : 3'd6;
      sw_valid = 1'b1;
      @(posedge clk);
      #1 sw_valid = 1'b0;
      lat1 = 0; lat32 = 0;
      for (int c = 1; c <= 40; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (s1_out_valid && lat1 == 0) lat1 = c;
        if (s32_out_valid && lat32 == 0) lat32 = c;
        if (lat1 != 0 && lat32 != 0) break;
      end
      check("ns1_lat", 32'(lat1), 32'd1);
      check("ns32_lat", 32'(lat32), 32'd32);
      check("ns1_out", s1_out, ref_op(sw_in1, sw_in2, sw_op));
      check("ns32_out", s32_out, ref_op(sw_in1, sw_in2, sw_op));
      check("ns32_zero", 32'(s32_zero), 32'(exp_zero(ref_op(sw_in1, sw_in2, sw_op))));
      sw_ready = 1'b1;
      @(posedge clk);
      #1 sw_ready = 1'b0;
      check("sweep_idle", 32'(s1_in_ready & s32_in_ready), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
